uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 13 +
 rtl/byte_fifo.sv | 57 +++++
 rtl/uart_tx_fifo.sv | 114 +++++++++++
 tb/tb_uart_tx_fifo.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and issue-FSM encoding for the buffered UART transmit path.
// Used by uart_tx_fifo.
package uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic {
        ISSUE_IDLE = 1'b0,
        ISSUE_WAIT = 1'b1
    } issue_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO, 2**DEPTH_LOG2 entries, pointers carry one extra wrap bit.
// Ports: clk100, rst (sync, high), wr_data/wr_en, rd_en/rd_data (show-ahead),
//        full, empty, level (all derived from registered pointers only).
module byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk100,
    input  logic                  rst,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2:0] rptr_q, rptr_d;
    logic                wr_ok;
    logic                rd_ok;

    // Occupancy can never exceed DEPTH, so its MSB alone flags full.
    assign level = wptr_q - rptr_q;
    assign empty = (wptr_q == rptr_q);
    assign full  = level[DEPTH_LOG2];

    // Writes are qualified by the pre-edge full, so a write on a full
    // FIFO is dropped even if a pop happens in the same cycle.
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    assign wptr_d = wptr_q + {{DEPTH_LOG2{1'b0}}, wr_ok};
    assign rptr_d = rptr_q + {{DEPTH_LOG2{1'b0}}, rd_ok};

    assign rd_data = mem_q[rptr_q[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk100) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk100) begin
        if (wr_ok) begin
            mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered front end for uart_tx: queues bytes and issues one frame at a time.
// Ports: clk100, rst (sync, high); wr_data/wr_en in; full, empty, level,
//        overflow (sticky) out; tx_data/tx_start to uart_tx; tx_busy and
//        tx_complete from uart_tx.
// Optional macro UART_TX_FIFO_CRLF_EN: a queued LF is sent as CR then LF.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk100,
    input  logic                  rst,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    input  logic                  tx_complete
);

    issue_state_e state_q, state_d;
    logic         tx_start_q, tx_start_d;
    logic [7:0]   tx_data_q, tx_data_d;
    logic         ovf_q, ovf_d;
    logic         rd_en;
    logic [7:0]   head;
`ifdef UART_TX_FIFO_CRLF_EN
    logic         crlf_pending_q, crlf_pending_d;
`endif

    byte_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk100  (clk100),
        .rst     (rst),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign ovf_d    = ovf_q | (wr_en & full);
    assign overflow = ovf_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

    // Issuing needs tx_busy low, which also covers a uart_tx that is
    // still finishing a frame started before our reset.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        rd_en      = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
        crlf_pending_d = crlf_pending_q;
`endif
        unique case (state_q)
            ISSUE_IDLE: begin
                if (!empty && !tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = ISSUE_WAIT;
`ifdef UART_TX_FIFO_CRLF_EN
                    // LF stays queued while its CR goes out.
                    if (head == ASCII_LF && !crlf_pending_q) begin
                        tx_data_d      = ASCII_CR;
                        crlf_pending_d = 1'b1;
                    end else begin
                        tx_data_d      = head;
                        rd_en          = 1'b1;
                        crlf_pending_d = 1'b0;
                    end
`else
                    tx_data_d = head;
                    rd_en     = 1'b1;
`endif
                end
            end
            ISSUE_WAIT: begin
                if (tx_complete) begin
                    state_d = ISSUE_IDLE;
                end
            end
            default: state_d = ISSUE_IDLE;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q    <= ISSUE_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            ovf_q      <= 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
            crlf_pending_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            ovf_q      <= ovf_d;
`ifdef UART_TX_FIFO_CRLF_EN
            crlf_pending_q <= crlf_pending_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a queue-based reference model
// and a simple uart_tx stand-in (fixed frame length, forceable busy).
module tb_uart_tx_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 12;

    logic          clk100 = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_en = 1'b0;
    logic          full, empty, overflow, tx_start;
    logic [DL:0]   level;
    logic [7:0]    tx_data;
    logic          tx_busy = 1'b0;
    logic          tx_complete = 1'b0;

    always #5 clk100 = ~clk100;

    uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
        .clk100      (clk100),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_complete (tx_complete)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_cpl = 0;
    bit chk_b2b = 0;
    bit force_busy = 0;
    int ucnt = 0;
    logic [7:0] sent[$];

    // reference model state (state after the most recent edge)
    logic [7:0] mq[$];
    bit         m_out = 0;
    bit         m_ovf = 0;
    bit         m_start = 0;
    bit         m_cr = 0;
    logic [7:0] m_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // uart_tx stand-in: busy the cycle after a start, complete pulse
    // together with busy falling at the end of the frame.
    always @(posedge clk100) begin
        tx_complete <= 1'b0;
        if (force_busy) begin
            tx_busy <= 1'b1;
        end else if (tx_start) begin
            tx_busy <= 1'b1;
            ucnt    <= FRAME;
        end else if (ucnt == 1) begin
            tx_busy     <= 1'b0;
            tx_complete <= 1'b1;
            ucnt        <= 0;
        end else if (ucnt > 1) begin
            ucnt <= ucnt - 1;
        end else begin
            tx_busy <= 1'b0;
        end
    end

    initial forever begin
        @(posedge clk100);
        cyc++;
    end

    // Compare DUT to model, then advance the model with the inputs the
    // DUT will sample at the coming edge.
    initial begin
        bit full_pre;
        bit pop;
        bit iss;
        forever begin
            @(negedge clk100);
            if (cyc > 0) begin
                chk("level", level, mq.size());
                chk("full", full, mq.size() == DEPTH);
                chk("empty", empty, mq.size() == 0);
                chk("overflow", overflow, m_ovf);
                chk("tx_start", tx_start, m_start);
                chk("tx_data", tx_data, m_data);
                if (tx_complete) last_cpl = cyc;
                if (tx_start) begin
                    chk("start_while_busy", tx_busy, 0);
                    sent.push_back(tx_data);
                    if (chk_b2b && sent.size() > 1)
                        chk("b2b_gap", cyc - last_cpl, 2);
                end
            end
            if (rst) begin
                mq.delete();
                m_out = 0; m_ovf = 0; m_start = 0;
                m_cr = 0; m_data = 8'h00;
            end else begin
                full_pre = (mq.size() == DEPTH);
                pop = 0;
                iss = 0;
                if (!m_out && mq.size() > 0 && !tx_busy) begin
                    iss = 1;
                    m_out = 1;
`ifdef UART_TX_FIFO_CRLF_EN
                    if (mq[0] == 8'h0A && !m_cr) begin
                        m_data = 8'h0D;
                        m_cr = 1;
                    end else begin
                        m_data = mq[0];
                        pop = 1;
                        m_cr = 0;
                    end
`else
                    m_data = mq[0];
                    pop = 1;
`endif
                end else if (m_out && tx_complete) begin
                    m_out = 0;
                end
                if (pop) void'(mq.pop_front());
                if (wr_en) begin
                    if (full_pre) m_ovf = 1;
                    else mq.push_back(wr_data);
                end
                m_start = iss;
            end
        end
    end

    task automatic step();
        @(posedge clk100);
        #2;
    endtask

    task automatic write(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_sent(input int n, input int budget,
                             input string name);
        int k = 0;
        while (sent.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(name, sent.size(), n);
    endtask

    task automatic wait_quiet(input string name);
        int k = 0;
        bit done = 0;
        while (!done && k < 600) begin
            done = !m_out && mq.size() == 0 && !tx_busy && ucnt == 0;
            if (!done) step();
            k++;
        end
        chk(name, done, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (3) step();
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        step();

        // three bytes, uart idle, back-to-back issue
        sent.delete();
        chk_b2b = 1;
        write(8'h41);
        write(8'h42);
        write(8'h43);
        wait_sent(3, 200, "t1_sent");
        if (sent.size() == 3) begin
            chk("t1_b0", sent[0], 8'h41);
            chk("t1_b1", sent[1], 8'h42);
            chk("t1_b2", sent[2], 8'h43);
        end
        wait_quiet("t1_quiet");
        chk_b2b = 0;

        // fill to 16 with uart held busy, 17th dropped
        force_busy = 1;
        step();
        step();
        sent.delete();
        for (int i = 0; i < 17; i++) write(8'h50 + 8'(i));
        chk("t2_level", level, 16);
        chk("t2_full", full, 1);
        chk("t2_overflow", overflow, 1);
        chk("t2_nostart", sent.size(), 0);

        // write while full in the same cycle as the pop
        force_busy = 0;
        for (int k = 0; k < 10; k++) begin
            if (tx_busy == 1'b0) break;
            step();
        end
        wr_en = 1'b1;
        wr_data = 8'h99;
        step();
        wr_en = 1'b0;
        chk("t3_level", level, 15);
        chk("t3_full", full, 0);
        chk("t3_start", tx_start, 1);
        wait_sent(16, 600, "t3_sent");
        wait_quiet("t3_quiet");
        chk("t3_count", sent.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < sent.size())
                chk("t3_order", sent[i], 8'h50 + 8'(i));
        end

        // LF handling
        sent.delete();
        write(8'h0A);
`ifdef UART_TX_FIFO_CRLF_EN
        wait_sent(1, 50, "t4_first");
        chk("t4_level_cr", level, 1);
        wait_sent(2, 50, "t4_second");
        wait_quiet("t4_quiet");
        if (sent.size() == 2) begin
            chk("t4_cr", sent[0], 8'h0D);
            chk("t4_lf", sent[1], 8'h0A);
        end
        chk("t4_level_end", level, 0);
`else
        wait_sent(1, 50, "t4_first");
        chk("t4_level_lf", level, 0);
        wait_quiet("t4_quiet");
        chk("t4_count", sent.size(), 1);
        if (sent.size() == 1) chk("t4_lf", sent[0], 8'h0A);
`endif

        // reset during WAIT with five bytes queued
        sent.delete();
        for (int i = 0; i < 6; i++) write(8'h60 + 8'(i));
        wait_sent(1, 50, "t5_first");
        step();
        step();
        chk("t5_busy", tx_busy, 1);
        chk("t5_level", level, 5);
        rst = 1'b1;
        step();
        step();
        chk("t5_empty", empty, 1);
        chk("t5_level0", level, 0);
        chk("t5_tx_start", tx_start, 0);
        rst = 1'b0;
        write(8'h77);
        chk("t5_busy_after", tx_busy, 1);
        chk("t5_held", tx_start, 0);
        wait_sent(2, 100, "t5_sent");
        wait_quiet("t5_quiet");
        chk("t5_count", sent.size(), 2);
        if (sent.size() == 2) begin
            chk("t5_b0", sent[0], 8'h60);
            chk("t5_b1", sent[1], 8'h77);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
